// File: rtl/buffer_ram_rnw1_if.sv
// Bus bundle for buffer_ram_rnw1: one write port, NUM_RD read ports and the status/error sideband.
// The master drives strobes, addresses and write data; the slave (the RAM) returns data, valids and status.
interface buffer_ram_rnw1_if #(
  parameter int WIDTH  = 64,
  parameter int NUM_RD = 4
);
  logic                    ready;
  logic                    wren;
  logic [31:0]             waddr;
  logic [WIDTH-1:0]        wdata;
  logic [NUM_RD-1:0]       rden;
  logic [NUM_RD*32-1:0]    raddr;
  logic [NUM_RD*WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]       rvalid;
  logic                    addr_err;
  logic                    err_clr;

  modport master (
    input  ready, rdata, rvalid, addr_err,
    output wren, waddr, wdata, rden, raddr, err_clr
  );

  modport slave (
    output ready, rdata, rvalid, addr_err,
    input  wren, waddr, wdata, rden, raddr, err_clr
  );
endinterface

// File: rtl/buffer_ram_rnw1.sv
// Multi-read, single-write operand buffer RAM: NUM_RD replicated read copies sharing one write port,
// a per-port read-valid pipeline, a post-reset clear sweep and a sticky out-of-range error flag.
module buffer_ram_rnw1 #(
  parameter int WIDTH          = 64,
  parameter int DEPTH          = 4096,
  parameter int NUM_RD         = 4,
  parameter int READ_LATENCY   = 2,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  buffer_ram_rnw1_if.slave    bus
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]     DEPTH_W   = 32'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   CNT_ONE   = AW'(32'd1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                    state_q;
  state_e                    state_d;
  logic [AW-1:0]             clr_cnt_q;
  logic [AW-1:0]             clr_cnt_d;
  logic                      ready_q;
  logic                      addr_err_q;
  logic                      clr_we_s;
  logic                      wr_oob_s;
  logic                      run_we_s;
  logic                      mem_we_s;
  logic [AW-1:0]             mem_waddr_s;
  logic [WIDTH-1:0]          mem_wdata_s;
  logic [NUM_RD-1:0]         rd_oob_s;
  logic [NUM_RD-1:0]         rd_launch_s;
  logic                      err_set_s;
  logic [NUM_RD-1:0]         rvalid_s;
  logic [NUM_RD*WIDTH-1:0]   rdata_s;

  // Clear-sweep sequencing: zero one word per cycle, then hand over to normal traffic.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we_s  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // ready lags the state by one register so the last sweep cycle never overlaps traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_q == ST_RUN);
    end
  end

  always_comb begin
    wr_oob_s    = (bus.waddr >= DEPTH_W);
    run_we_s    = ready_q && bus.wren && !wr_oob_s;
    mem_we_s    = !rst && (clr_we_s || run_we_s);
    rd_oob_s    = '0;
    rd_launch_s = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_oob_s[p]    = (bus.raddr[32*p +: 32] >= DEPTH_W);
      rd_launch_s[p] = ready_q && bus.rden[p];
    end
    err_set_s = ready_q && ((bus.wren && wr_oob_s) || (|(bus.rden & rd_oob_s)));
    if (clr_we_s) begin
      mem_waddr_s = clr_cnt_q;
      mem_wdata_s = '0;
    end else begin
      mem_waddr_s = bus.waddr[AW-1:0];
      mem_wdata_s = bus.wdata;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err_q <= 1'b0;
    end else if (err_set_s) begin
      addr_err_q <= 1'b1;
    end else if (bus.err_clr) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_q;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [31:0]             raddr_s;
    logic                    hit_s;
    logic [WIDTH-1:0]        rd_word_s;
    logic [WIDTH-1:0]        dat_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_q;

    assign raddr_s = bus.raddr[32*p +: 32];

    // Private copy of the array; every copy sees the same write stream.
    always_ff @(posedge clk) begin
      if (mem_we_s) begin
        mem_q[mem_waddr_s] <= mem_wdata_s;
      end
    end

    always_comb begin
      hit_s = (WRITE_FIRST != 0) && run_we_s && (bus.waddr == raddr_s);
      if (rd_oob_s[p]) begin
        rd_word_s = '0;
      end else if (hit_s) begin
        rd_word_s = bus.wdata;
      end else begin
        rd_word_s = mem_q[raddr_s[AW-1:0]];
      end
    end

    // Data stages only load on a valid beat, so rdata holds its last value between pulses.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
          dat_q[k] <= '0;
        end
      end else begin
        vld_q[0] <= rd_launch_s[p];
        if (rd_launch_s[p]) begin
          dat_q[0] <= rd_word_s;
        end
        for (int k = 1; k < READ_LATENCY; k++) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            dat_q[k] <= dat_q[k-1];
          end
        end
      end
    end

    assign rvalid_s[p]                = vld_q[READ_LATENCY-1];
    assign rdata_s[WIDTH*p +: WIDTH]  = dat_q[READ_LATENCY-1];
  end

  assign bus.ready    = ready_q;
  assign bus.addr_err = addr_err_q;
  assign bus.rvalid   = rvalid_s;
  assign bus.rdata    = rdata_s;

endmodule

// File: tb/tb_buffer_ram_rnw1.sv
// Bench for buffer_ram_rnw1: a write-first/latency-2 and a read-old/latency-3 instance share one
// stimulus stream and are compared against an array model with per-port delivery schedules.
module tb_buffer_ram_rnw1;
  localparam int W  = 64;
  localparam int D  = 16;
  localparam int NR = 4;
  localparam int LA = 2;
  localparam int LB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             wren;
  logic             err_clr;
  logic [31:0]      waddr;
  logic [W-1:0]     wdata;
  logic [NR-1:0]    rden;
  logic [NR*32-1:0] raddr;

  buffer_ram_rnw1_if #(.WIDTH(W), .NUM_RD(NR)) ifa ();
  buffer_ram_rnw1_if #(.WIDTH(W), .NUM_RD(NR)) ifb ();

  assign ifa.wren = wren;   assign ifb.wren = wren;
  assign ifa.waddr = waddr; assign ifb.waddr = waddr;
  assign ifa.wdata = wdata; assign ifb.wdata = wdata;
  assign ifa.rden = rden;   assign ifb.rden = rden;
  assign ifa.raddr = raddr; assign ifb.raddr = raddr;
  assign ifa.err_clr = err_clr; assign ifb.err_clr = err_clr;

  buffer_ram_rnw1 #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .READ_LATENCY(LA),
                    .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  buffer_ram_rnw1 #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .READ_LATENCY(LB),
                    .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model
  logic [W-1:0] mem_m [D];
  int           since_m = 0;
  logic         rdy_m = 1'b0;
  logic         err_m = 1'b0;
  bit   [7:0]   sa_v [NR];
  bit   [7:0]   sb_v [NR];
  logic [W-1:0] sa_d [NR][8];
  logic [W-1:0] sb_d [NR][8];
  logic [W-1:0] last_a [NR];
  logic [W-1:0] last_b [NR];
  logic         exp_va [NR];
  logic         exp_vb [NR];
  logic [W-1:0] exp_da [NR];
  logic [W-1:0] exp_db [NR];

  task automatic idle();
    wren = 1'b0; rden = '0; err_clr = 1'b0;
  endtask

  // Applies the current inputs to the model, clocks once, and leaves us at the following negedge.
  task automatic step();
    int n; int s; logic [31:0] a; logic [W-1:0] va; logic [W-1:0] vb; bit en;
    n = cyc + 1;
    if (rst) begin
      for (int p = 0; p < NR; p++) begin
        sa_v[p] = 8'h0; sb_v[p] = 8'h0; last_a[p] = '0; last_b[p] = '0;
      end
      since_m = 0; rdy_m = 1'b0; err_m = 1'b0;
    end else begin
      en = 1'b0;
      if (rdy_m) begin
        for (int p = 0; p < NR; p++) begin
          if (rden[p]) begin
            a = raddr[32*p +: 32];
            if (a >= 32'(D)) begin
              va = '0; vb = '0; en = 1'b1;
            end else begin
              vb = mem_m[a];
              va = (wren && waddr == a) ? wdata : mem_m[a];
            end
            sa_v[p][(n+LA-1)%8] = 1'b1; sa_d[p][(n+LA-1)%8] = va;
            sb_v[p][(n+LB-1)%8] = 1'b1; sb_d[p][(n+LB-1)%8] = vb;
          end
        end
        if (wren) begin
          if (waddr >= 32'(D)) en = 1'b1;
          else mem_m[waddr] = wdata;
        end
      end
      since_m++;
      if (since_m <= D) mem_m[since_m-1] = '0;
      err_m = en ? 1'b1 : (err_clr ? 1'b0 : err_m);
      rdy_m = (since_m >= D + 1);
    end
    @(posedge clk);
    cyc = n;
    s = n % 8;
    for (int p = 0; p < NR; p++) begin
      exp_va[p] = sa_v[p][s]; if (sa_v[p][s]) last_a[p] = sa_d[p][s]; sa_v[p][s] = 1'b0;
      exp_vb[p] = sb_v[p][s]; if (sb_v[p][s]) last_b[p] = sb_d[p][s]; sb_v[p][s] = 1'b0;
      exp_da[p] = last_a[p]; exp_db[p] = last_b[p];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); waddr = '0; wdata = '0; raddr = '0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    for (int k = 1; k <= D + 1; k++) begin
      step();
      checks++;
      if (ifa.ready !== (k >= D + 1) || ifb.ready !== (k >= D + 1))
        $display("FAIL reset_ready k=%0d: got %b%b want %b", k, ifa.ready, ifb.ready, (k >= D + 1));
      else passes++;
      checks++;
      if ({ifa.rvalid, ifb.rvalid, ifa.rdata, ifb.rdata, ifa.addr_err, ifb.addr_err} !== '0)
        $display("FAIL reset_idle k=%0d: got rv=%h/%h err=%b%b want all zero", k, ifa.rvalid, ifb.rvalid, ifa.addr_err, ifb.addr_err);
      else passes++;
    end
    for (int a = 0; a < D + LB; a++) begin
      idle();
      if (a < D) begin rden = 4'b0001 << (a % NR); raddr[32*(a % NR) +: 32] = 32'(a); end
      step();
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (ifa.rvalid[p] !== exp_va[p] || ifa.rdata[W*p +: W] !== exp_da[p])
          $display("FAIL clear_read A p%0d: got v=%b d=%h want v=%b d=%h", p, ifa.rvalid[p], ifa.rdata[W*p +: W], exp_va[p], exp_da[p]);
        else passes++;
        checks++;
        if (ifb.rvalid[p] !== exp_vb[p] || ifb.rdata[W*p +: W] !== exp_db[p])
          $display("FAIL clear_read B p%0d: got v=%b d=%h want v=%b d=%h", p, ifb.rvalid[p], ifb.rdata[W*p +: W], exp_vb[p], exp_db[p]);
        else passes++;
      end
    end
  endtask

  task automatic test_write_read();
    idle(); wren = 1'b1; waddr = 32'd5; wdata = 64'hDEAD_BEEF_0000_0001; step();
    idle(); rden = 4'hF;
    for (int p = 0; p < NR; p++) raddr[32*p +: 32] = 32'd5;
    step();
    for (int k = 1; k <= LB + 1; k++) begin
      idle(); step();
      checks++;
      if (ifa.rvalid !== ((k == LA - 1) ? 4'hF : 4'h0) || ifb.rvalid !== ((k == LB - 1) ? 4'hF : 4'h0))
        $display("FAIL wr_rd_valid k=%0d: got %h/%h", k, ifa.rvalid, ifb.rvalid);
      else passes++;
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (ifa.rdata[W*p +: W] !== exp_da[p] || ifb.rdata[W*p +: W] !== exp_db[p] ||
            (k >= LB - 1 && ifb.rdata[W*p +: W] !== 64'hDEAD_BEEF_0000_0001))
          $display("FAIL wr_rd_data p%0d: got %h/%h want %h/%h", p, ifa.rdata[W*p +: W], ifb.rdata[W*p +: W], exp_da[p], exp_db[p]);
        else passes++;
      end
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] qa[$]; logic [W-1:0] qb[$];
    idle(); wren = 1'b1; waddr = 32'd3; wdata = 64'h11; step();
    idle(); wren = 1'b1; waddr = 32'd3; wdata = 64'hAA; rden = 4'b0001; raddr[31:0] = 32'd3; step();
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k == 0) begin rden = 4'b0001; raddr[31:0] = 32'd3; end
      step();
      if (ifa.rvalid[0] === 1'b1) qa.push_back(ifa.rdata[W-1:0]);
      if (ifb.rvalid[0] === 1'b1) qb.push_back(ifb.rdata[W-1:0]);
      checks++;
      if (ifa.rvalid[0] !== exp_va[0] || ifa.rdata[W-1:0] !== exp_da[0] || ifb.rvalid[0] !== exp_vb[0] || ifb.rdata[W-1:0] !== exp_db[0])
        $display("FAIL collide_model k=%0d: got %b:%h %b:%h want %b:%h %b:%h", k, ifa.rvalid[0], ifa.rdata[W-1:0],
                 ifb.rvalid[0], ifb.rdata[W-1:0], exp_va[0], exp_da[0], exp_vb[0], exp_db[0]);
      else passes++;
    end
    checks++;
    if (qa.size() != 2 || qa[0] !== 64'hAA || qa[1] !== 64'hAA)
      $display("FAIL collide_write_first: got n=%0d %h %h want 2 aa aa", qa.size(), qa[0], qa[1]);
    else passes++;
    checks++;
    if (qb.size() != 2 || qb[0] !== 64'h11 || qb[1] !== 64'hAA)
      $display("FAIL collide_read_old: got n=%0d %h %h want 2 11 aa", qb.size(), qb[0], qb[1]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] wrote [D]; logic [W-1:0] qa[$]; int ca[$]; logic [W-1:0] qb[$];
    for (int a = 0; a < D; a++) begin
      wrote[a] = {$urandom, $urandom};
      idle(); wren = 1'b1; waddr = 32'(a); wdata = wrote[a]; step();
    end
    for (int a = 0; a < D + LB + 1; a++) begin
      idle();
      if (a < D) begin rden = 4'b0100; raddr[64 +: 32] = 32'(a); end
      step();
      if (ifa.rvalid[2] === 1'b1) begin qa.push_back(ifa.rdata[2*W +: W]); ca.push_back(cyc); end
      if (ifb.rvalid[2] === 1'b1) qb.push_back(ifb.rdata[2*W +: W]);
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (ifa.rvalid[p] !== exp_va[p] || ifa.rdata[W*p +: W] !== exp_da[p] || ifb.rvalid[p] !== exp_vb[p] || ifb.rdata[W*p +: W] !== exp_db[p])
          $display("FAIL b2b_model p%0d: got %b:%h %b:%h want %b:%h %b:%h", p, ifa.rvalid[p], ifa.rdata[W*p +: W],
                   ifb.rvalid[p], ifb.rdata[W*p +: W], exp_va[p], exp_da[p], exp_vb[p], exp_db[p]);
        else passes++;
      end
    end
    checks++;
    if (qa.size() != D || qb.size() != D || ca[D-1] - ca[0] != D - 1)
      $display("FAIL b2b_pulses: got na=%0d nb=%0d span=%0d want %0d %0d %0d", qa.size(), qb.size(), ca[ca.size()-1] - ca[0], D, D, D - 1);
    else passes++;
    for (int a = 0; a < D; a++) begin
      checks++;
      if (qa[a] !== wrote[a] || qb[a] !== wrote[a])
        $display("FAIL b2b_data a=%0d: got %h/%h want %h", a, qa[a], qb[a], wrote[a]);
      else passes++;
    end
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] v4; logic [W-1:0] qa[$];
    v4 = {$urandom, $urandom};
    idle(); wren = 1'b1; waddr = 32'd4; wdata = v4; step();
    idle(); rden = 4'b0010; raddr[32 +: 32] = 32'd16; wren = 1'b1; waddr = 32'd20; wdata = ~v4; step();
    checks++;
    if (ifa.addr_err !== 1'b1 || ifb.addr_err !== 1'b1)
      $display("FAIL oob_err_set: got %b%b want 11", ifa.addr_err, ifb.addr_err);
    else passes++;
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k == 0) begin rden = 4'b0010; raddr[32 +: 32] = 32'd4; end
      step();
      if (ifa.rvalid[1] === 1'b1) qa.push_back(ifa.rdata[W +: W]);
      checks++;
      if (ifa.rvalid[1] !== exp_va[1] || ifa.rdata[W +: W] !== exp_da[1] || ifb.rvalid[1] !== exp_vb[1] ||
          ifb.rdata[W +: W] !== exp_db[1] || ifa.addr_err !== err_m || ifb.addr_err !== err_m)
        $display("FAIL oob_model k=%0d: got %b:%h %b:%h err=%b%b want %b:%h %b:%h err=%b", k, ifa.rvalid[1], ifa.rdata[W +: W],
                 ifb.rvalid[1], ifb.rdata[W +: W], ifa.addr_err, ifb.addr_err, exp_va[1], exp_da[1], exp_vb[1], exp_db[1], err_m);
      else passes++;
    end
    checks++;
    if (qa.size() != 2 || qa[0] !== 64'h0 || qa[1] !== v4)
      $display("FAIL oob_read: got n=%0d %h %h want 2 0 %h", qa.size(), qa[0], qa[1], v4);
    else passes++;
    idle(); err_clr = 1'b1; rden = 4'b1000; raddr[96 +: 32] = 32'd100; step();
    checks++;
    if (ifa.addr_err !== 1'b1 || ifb.addr_err !== 1'b1)
      $display("FAIL oob_set_wins: got %b%b want 11", ifa.addr_err, ifb.addr_err);
    else passes++;
    idle(); err_clr = 1'b1; step();
    idle(); step();
    checks++;
    if (ifa.addr_err !== 1'b0 || ifb.addr_err !== 1'b0)
      $display("FAIL oob_clear: got %b%b want 00", ifa.addr_err, ifb.addr_err);
    else passes++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      wren = 1'($urandom_range(0, 1)); waddr = 32'($urandom_range(0, 19)); wdata = {$urandom, $urandom};
      rden = 4'($urandom_range(0, 15)); err_clr = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < NR; p++)
        raddr[32*p +: 32] = ($urandom_range(0, 3) == 0) ? waddr : 32'($urandom_range(0, 19));
      step();
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (ifa.rvalid[p] !== exp_va[p] || ifa.rdata[W*p +: W] !== exp_da[p] || ifb.rvalid[p] !== exp_vb[p] || ifb.rdata[W*p +: W] !== exp_db[p])
          $display("FAIL random_rd k=%0d p%0d: got %b:%h %b:%h want %b:%h %b:%h", k, p, ifa.rvalid[p], ifa.rdata[W*p +: W],
                   ifb.rvalid[p], ifb.rdata[W*p +: W], exp_va[p], exp_da[p], exp_vb[p], exp_db[p]);
        else passes++;
      end
      checks++;
      if ({ifa.ready, ifb.ready, ifa.addr_err, ifb.addr_err} !== {rdy_m, rdy_m, err_m, err_m})
        $display("FAIL random_ctl k=%0d: got rdy=%b%b err=%b%b want rdy=%b err=%b", k, ifa.ready, ifb.ready, ifa.addr_err, ifb.addr_err, rdy_m, err_m);
      else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    int pulses; logic [W-1:0] qa[$];
    pulses = 0;
    idle(); rden = 4'b0111;
    for (int p = 0; p < NR; p++) raddr[32*p +: 32] = 32'($urandom_range(0, D - 1));
    step();
    idle(); rst = 1'b1; wren = 1'b1; waddr = 32'd7; wdata = 64'h1234; step();
    idle(); rst = 1'b0;
    for (int k = 1; k <= D + 1; k++) begin
      step();
      pulses += $countones(ifa.rvalid) + $countones(ifb.rvalid);
      checks++;
      if (ifa.ready !== (k >= D + 1) || ifb.ready !== (k >= D + 1))
        $display("FAIL midrst_ready k=%0d: got %b%b want %b", k, ifa.ready, ifb.ready, (k >= D + 1));
      else passes++;
    end
    checks++;
    if (pulses != 0) $display("FAIL midrst_pulses: got %0d want 0", pulses);
    else passes++;
    for (int a = 0; a < D + LB; a++) begin
      idle();
      if (a < D) begin rden = 4'b0001; raddr[31:0] = 32'(a); end
      step();
      if (ifa.rvalid[0] === 1'b1) qa.push_back(ifa.rdata[W-1:0]);
      checks++;
      if (ifa.rvalid[0] !== exp_va[0] || ifa.rdata[W-1:0] !== exp_da[0] || ifb.rvalid[0] !== exp_vb[0] || ifb.rdata[W-1:0] !== exp_db[0])
        $display("FAIL midrst_read a=%0d: got %b:%h %b:%h want %b:%h %b:%h", a, ifa.rvalid[0], ifa.rdata[W-1:0],
                 ifb.rvalid[0], ifb.rdata[W-1:0], exp_va[0], exp_da[0], exp_vb[0], exp_db[0]);
      else passes++;
    end
    checks++;
    if (qa.size() != D || qa.sum() !== 64'h0)
      $display("FAIL midrst_cleared: got n=%0d sum=%h want %0d 0", qa.size(), qa.sum(), D);
    else passes++;
  endtask

  initial begin
    for (int a = 0; a < D; a++) mem_m[a] = '0;
    rst = 1'b1;
    idle(); waddr = '0; wdata = '0; raddr = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/buffer_ram_rnw1.md
Name: buffer_ram_rnw1

Overview:
Parametrised multi-read, single-write buffer RAM for the FHE ALU datapath. It generalises the fixed R2W1/R3W1/R4W1 buffer RAM port bundles to NUM_RD read ports of configurable width, depth and read latency. It adds a per-port read-valid pipeline, a selectable read/write collision policy, an optional post-reset clear sweep, and sticky address-error reporting. It sits between the vector/NTT engines and the DMA load/store path as the common operand buffer.

Parameters:
WIDTH, 64, data word width in bits (FSIZE; E*FSIZE for lane-wide instances)
DEPTH, 4096, number of words (IN_BUFFER_SIZE); power of two not required
NUM_RD, 4, number of independent read ports (1..8)
READ_LATENCY, 2, cycles from rden to rvalid/rdata (>=1; BUFFER_READ_LATENCY)
WRITE_FIRST, 1, collision policy: 1 = same-cycle read of the written address returns wdata; 0 = returns old data
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ready  out  1  high when the block accepts reads/writes
wren  in  1  write strobe
waddr  in  32  write word address
wdata  in  WIDTH  write data
rden  in  NUM_RD  per-port read strobe
raddr  in  NUM_RD*32  per-port read address; port i = bits [32*i+31:32*i]
rdata  out  NUM_RD*WIDTH  per-port read data; port i = bits [WIDTH*i+WIDTH-1:WIDTH*i]
rvalid  out  NUM_RD  per-port read-data valid
addr_err  out  1  sticky out-of-range access flag
err_clr  in  1  clears addr_err

Behaviour:
- Reset (rst=1 at a clock edge) sets: ready=0, rvalid=0, rdata=0, addr_err=0, clear counter=0, all read-pipeline stages invalid. Memory contents are untouched by reset itself.
- FSM states: CLEAR, RUN.
  - rst enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - CLEAR writes 0 to address clr_cnt each cycle, for clr_cnt = 0..DEPTH-1. After writing DEPTH-1 it moves to RUN.
  - ready=1 exactly in RUN (registered). With CLEAR_ON_RESET=1, ready rises DEPTH+1 cycles after the first cycle with rst low. With CLEAR_ON_RESET=0, it rises 1 cycle after rst low.
- In CLEAR, wren and rden are ignored: no memory effect, no rvalid, no addr_err. Upstream must gate on ready.
- Read in RUN:
  - rden[i]=1 at cycle t launches a read of raddr[i].
  - rvalid[i]=1 and rdata[i] = mem[raddr[i]] appear at cycle t+READ_LATENCY.
  - Full throughput: one read per port per cycle, with all ports independent. Several ports may read the same address.
- rvalid[i] is high for exactly one cycle per accepted rden. rdata[i] holds its last value while rvalid[i]=0; consumers sample only on rvalid.
- Write in RUN: wren=1 at cycle t updates mem[waddr] at the t edge. A read launched at t+1 or later sees the new data.
- Same-cycle collision (wren and rden[i] in the same cycle, with waddr==raddr[i]):
  - WRITE_FIRST=1: the read returns wdata.
  - WRITE_FIRST=0: the read returns the pre-write word.
  - The policy applies independently per port.
- Out of range (address >= DEPTH):
  - Read: rvalid still asserts at the normal latency, with rdata=0.
  - Write: dropped.
  - Either case sets addr_err on the next cycle.
- addr_err stays set until err_clr=1. If err_clr and a new error occur in the same cycle, the set wins.
- Reset mid-operation: all in-flight reads are discarded, rvalid=0 from the next cycle, and the FSM restarts CLEAR from address 0. A write coinciding with the rst edge is dropped.
- Memory is inferred as registered block RAM. Read ports are realised as replicated copies sharing the write port. Output registers provide READ_LATENCY; extra stages are pipeline registers.

Test Plan:
- Reset and clear, DEPTH=16, CLEAR_ON_RESET=1 → ready=0 for 16 cycles after rst falls, then 1. A read of any address then returns 0 with rvalid after 2 cycles.
- Write 0xDEAD_BEEF_0000_0001 to address 5, then rden on all 4 ports at address 5 on the next cycle → all rvalid=1 exactly 2 cycles later, all rdata=0xDEAD_BEEF_0000_0001.
- Same-cycle write of 0xAA to address 3 (old value 0x11) with rden[0] at address 3:
  - WRITE_FIRST=1 → 0xAA.
  - WRITE_FIRST=0 → 0x11; a read on the next cycle returns 0xAA.
- Back-to-back reads on port 2 of addresses 0..15 in 16 consecutive cycles → 16 consecutive rvalid pulses with matching data, no bubbles; other ports are idle with rvalid=0.
- Read of address 16 and write to address 20 with DEPTH=16:
  - The read returns rdata=0 with rvalid asserted.
  - The write is dropped (address 4 is unchanged).
  - addr_err=1 and stays set until err_clr. If err_clr is asserted with a new bad access in the same cycle, addr_err remains 1.
- Assert rst while 3 reads are in flight → no rvalid pulses afterwards, ready=0, and the clear sweep restarts from 0.
